// File: rtl/encoder16x4_queue_if.sv
// rtl/encoder16x4_queue_if.sv - request intake and index issue bus for the 16-to-4 encoder queue
interface encoder16x4_queue_if;
   logic        enable;
   logic [15:0] req;
   logic        out_ready;
   logic        clr_ovf;
   logic        out_valid;
   logic [3:0]  out_idx;
   logic [15:0] pending;
   logic        any_pend;
   logic        overflow;

   modport master (
      output enable, req, out_ready, clr_ovf,
      input  out_valid, out_idx, pending, any_pend, overflow
   );

   modport slave (
      input  enable, req, out_ready, clr_ovf,
      output out_valid, out_idx, pending, any_pend, overflow
   );
endinterface

// File: rtl/encoder16x4_queue.sv
// rtl/encoder16x4_queue.sv - registered 16-to-4 encoder queue
// Latches request lines as pending, then issues their indices lowest-first over valid/ready.
module encoder16x4_queue #(
   parameter int N_IN  = 16,
   parameter int IDX_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   encoder16x4_queue_if.slave  bus
);

   logic [N_IN-1:0]  pending_q, pending_d;
   logic             out_valid_q, out_valid_d;
   logic [IDX_W-1:0] out_idx_q, out_idx_d;
   logic             overflow_q, overflow_d;

   logic [IDX_W-1:0] sel;
   logic             load;
   logic [N_IN-1:0]  clr;
   logic [N_IN-1:0]  req_eff;
   logic             ovf_set;

   // Scan high-to-low so the lowest set bit is the last assignment.
   always_comb begin
      sel = '0;
      for (int i = N_IN - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            sel = IDX_W'(i);
         end
      end
   end

   always_comb begin
      load       = bus.enable & (~out_valid_q | bus.out_ready) & (|pending_q);
      clr        = load ? (N_IN'(1) << sel) : '0;
      req_eff    = bus.enable ? bus.req : '0;
      // OR-ing req after the clear lets a same-cycle request re-queue the issued line.
      pending_d  = (pending_q & ~clr) | req_eff;
      ovf_set    = bus.enable & (|(bus.req & pending_q & ~clr));
      overflow_d = overflow_q;
      if (ovf_set) begin
         overflow_d = 1'b1;
      end else if (bus.clr_ovf) begin
         overflow_d = 1'b0;
      end

      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_idx_d   = sel;
      end else if (out_valid_q & bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q   <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         overflow_q  <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         overflow_q  <= overflow_d;
      end
   end

   assign bus.pending   = pending_q;
   assign bus.any_pend  = |pending_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_encoder16x4_queue.sv
// tb/tb_encoder16x4_queue.sv - directed vector bench for encoder16x4_queue
module tb_encoder16x4_queue;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   encoder16x4_queue_if bus ();

   encoder16x4_queue dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        en;
      logic [15:0] req;
      logic        rdy;
      logic        clr;
      logic        v;
      logic [3:0]  idx;
      logic [15:0] pend;
      logic        ovf;
   } vec_t;

   localparam int NV = 28;
   vec_t vecs [NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic en, input logic [15:0] req, input logic rdy, input logic clr);
      bus.enable    = en;
      bus.req       = req;
      bus.out_ready = rdy;
      bus.clr_ovf   = clr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic v, input logic [3:0] idx,
                            input logic [15:0] pend, input logic ovf);
      chk({tag, ".valid"},    32'(bus.out_valid), 32'(v));
      chk({tag, ".idx"},      32'(bus.out_idx),   32'(idx));
      chk({tag, ".pending"},  32'(bus.pending),   32'(pend));
      chk({tag, ".any_pend"}, 32'(bus.any_pend),  32'(pend != 16'h0));
      chk({tag, ".overflow"}, 32'(bus.overflow),  32'(ovf));
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      //          en  req       rdy   clr   v     idx   pend      ovf
      vecs[0]  = '{1'b1, 16'h0020, 1'b1, 1'b0, 1'b0, 4'h0, 16'h0020, 1'b0};
      vecs[1]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h5, 16'h0000, 1'b0};
      vecs[2]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h5, 16'h0000, 1'b0};
      vecs[3]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h5, 16'h0000, 1'b0};
      vecs[4]  = '{1'b1, 16'h8208, 1'b1, 1'b0, 1'b0, 4'h5, 16'h8208, 1'b0};
      vecs[5]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h3, 16'h8200, 1'b0};
      vecs[6]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h9, 16'h8000, 1'b0};
      vecs[7]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 4'hF, 16'h0000, 1'b0};
      vecs[8]  = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'hF, 16'h0000, 1'b0};
      vecs[9]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b0, 4'hF, 16'h0003, 1'b0};
      vecs[10] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0002, 1'b0};
      vecs[11] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0002, 1'b0};
      vecs[12] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0002, 1'b0};
      vecs[13] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0002, 1'b0};
      vecs[14] = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h1, 16'h0000, 1'b0};
      vecs[15] = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h1, 16'h0000, 1'b0};
      vecs[16] = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 4'h1, 16'h0001, 1'b0};
      vecs[17] = '{1'b1, 16'h0010, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0010, 1'b0};
      vecs[18] = '{1'b1, 16'h0010, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0010, 1'b1};
      vecs[19] = '{1'b1, 16'h0010, 1'b0, 1'b1, 1'b1, 4'h0, 16'h0010, 1'b1};
      vecs[20] = '{1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 4'h0, 16'h0010, 1'b0};
      vecs[21] = '{1'b1, 16'h0010, 1'b1, 1'b0, 1'b1, 4'h4, 16'h0010, 1'b0};
      vecs[22] = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h4, 16'h0000, 1'b0};
      vecs[23] = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 4'h4, 16'h0000, 1'b0};
      vecs[24] = '{1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4'h4, 16'h0000, 1'b0};
      vecs[25] = '{1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4'h4, 16'h0000, 1'b0};
      vecs[26] = '{1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 4'h4, 16'hFFFF, 1'b0};
      vecs[27] = '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 4'h0, 16'hFFFE, 1'b0};

      rst_n = 1'b0;
      drive(1'b0, 16'h0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk_state("reset", 1'b0, 4'h0, 16'h0, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].en, vecs[i].req, vecs[i].rdy, vecs[i].clr);
         step();
         chk_state($sformatf("vec%0d", i), vecs[i].v, vecs[i].idx, vecs[i].pend, vecs[i].ovf);
      end

      // Continue draining the all-lines-pending set: indices 1..15 back to back.
      drive(1'b1, 16'h0, 1'b1, 1'b0);
      for (int k = 1; k < 16; k++) begin
         logic [31:0] rem;
         rem = (32'h0000FFFF << (k + 1)) & 32'h0000FFFF;
         step();
         chk_state($sformatf("drain%0d", k), 1'b1, 4'(k), rem[15:0], 1'b0);
      end
      step();
      chk_state("drain_end", 1'b0, 4'hF, 16'h0, 1'b0);

      // A held out_valid completes while enable=0, but nothing new loads.
      drive(1'b1, 16'h0006, 1'b0, 1'b0);
      step();
      drive(1'b1, 16'h0000, 1'b0, 1'b0);
      step();
      chk_state("hold_load", 1'b1, 4'h1, 16'h0004, 1'b0);
      drive(1'b0, 16'h0000, 1'b1, 1'b0);
      step();
      chk_state("dis_complete", 1'b0, 4'h1, 16'h0004, 1'b0);
      step();
      chk_state("dis_frozen", 1'b0, 4'h1, 16'h0004, 1'b0);
      drive(1'b1, 16'h0000, 1'b1, 1'b0);
      step();
      chk_state("reenable", 1'b1, 4'h2, 16'h0000, 1'b0);
      step();
      chk_state("reenable_done", 1'b0, 4'h2, 16'h0000, 1'b0);

      // Asynchronous reset mid-stream with pending=00F0 and a held index.
      drive(1'b1, 16'h00F8, 1'b0, 1'b0);
      step();
      drive(1'b1, 16'h0000, 1'b0, 1'b0);
      step();
      chk_state("pre_reset", 1'b1, 4'h3, 16'h00F0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_state("async_reset", 1'b0, 4'h0, 16'h0, 1'b0);
      step();
      rst_n = 1'b1;
      drive(1'b0, 16'h0, 1'b0, 1'b0);
      step();
      chk_state("post_reset", 1'b0, 4'h0, 16'h0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
